// File: rtl/vgac_param.sv
// vgac_param: parameterised VGA timing generator with pixel-RAM read stage and test patterns
module vgac_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                  vga_clk,
  input  logic                  clrn,
  input  logic [1:0]            mode,
  input  logic [RW+GW+BW-1:0]   d_in,
  output logic [9:0]            row_addr,
  output logic [10:0]           col_addr,
  output logic                  rdn,
  output logic [RW-1:0]         r,
  output logic [GW-1:0]         g,
  output logic [BW-1:0]         b,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic                  frame_start
);
  localparam int CW = RW + GW + BW;
  localparam int D  = RD_LAT + 1;
  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [10:0] H_LAST   = 11'(HT - 1);
  localparam logic [10:0] V_LAST   = 11'(VT - 1);
  localparam logic [10:0] HA_L     = 11'(H_SYNC + H_BP);
  localparam logic [10:0] VA_L     = 11'(V_SYNC + V_BP);
  localparam logic [10:0] HS_END   = 11'(H_SYNC);
  localparam logic [10:0] VS_END   = 11'(V_SYNC);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
  localparam logic [10:0] BAR_W    = 11'(H_ACTIVE / 8);
  localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);
  localparam logic        HS_ON    = 1'(HS_POL);
  localparam logic        VS_ON    = 1'(VS_POL);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          fs;
    logic          fb;
    logic [CW-1:0] pat;
  } stage_t;

  localparam stage_t ST_RST = stage_t'({~HS_ON, ~VS_ON, 3'b000, CW'(0)});

  logic [10:0]   h_q, v_q, h_d, v_d;
  logic [1:0]    mode_q;
  logic [10:0]   col_c, row_c, bar;
  logic [2:0]    idx;
  logic          act, edge_px;
  stage_t        st_c;
  stage_t        pipe_q [D];
  logic          rdn_q;
  logic [10:0]   col_q;
  logic [9:0]    row_q;
  logic          hs_q, vs_q, de_q, fs_q;
  logic [CW-1:0] rgb_q;

  // next counter state, visible-region decode and per-pixel pattern colour
  always_comb begin
    h_d = h_q == H_LAST ? '0 : h_q + 11'd1;
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + 11'd1;
    col_c = h_q - HA_L;
    row_c = v_q - VA_L;
    act = h_q >= HA_L && {1'b0, col_c} < H_ACT_W && v_q >= VA_L && {1'b0, row_c} < V_ACT_W;
    bar = col_c / BAR_W;
    idx = bar > 11'd7 ? 3'd7 : bar[2:0];
    edge_px = row_c == 11'd0 || row_c == ROW_LAST || col_c == 11'd0 || col_c == COL_LAST;
    st_c.hs = h_q < HS_END ? HS_ON : ~HS_ON;
    st_c.vs = v_q < VS_END ? VS_ON : ~VS_ON;
    st_c.de = act;
    st_c.fs = h_q == HA_L && v_q == VA_L;
    st_c.fb = mode_q == 2'd0;
    st_c.pat = mode_q == 2'd1 ? {{RW{idx[2]}}, {GW{idx[1]}}, {BW{idx[0]}}} :
               mode_q == 2'd2 ? {CW{edge_px}} : '0;
  end

  // pixel/line counters; mode is only sampled at the frame origin
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= h_q == 11'd0 && v_q == 11'd0 ? mode : mode_q;
    end
  end

  // pixel-RAM read stage, one cycle behind the counters
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      rdn_q <= 1'b1;
      col_q <= '0;
      row_q <= '0;
    end else begin
      rdn_q <= ~act;
      col_q <= act ? col_c : '0;
      row_q <= act ? row_c[9:0] : '0;
    end
  end

  // delay line holding timing and pattern until the RAM word arrives
  always_ff @(posedge vga_clk) begin
    pipe_q[0] <= !clrn ? ST_RST : st_c;
    for (int k = 1; k < D; k++) pipe_q[k] <= !clrn ? ST_RST : pipe_q[k-1];
  end

  // output register: merge RAM data or pattern, blank outside the visible area
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= pipe_q[D-1].hs;
      vs_q  <= pipe_q[D-1].vs;
      de_q  <= pipe_q[D-1].de;
      fs_q  <= pipe_q[D-1].fs;
      rgb_q <= !pipe_q[D-1].de ? '0 : pipe_q[D-1].fb ? d_in : pipe_q[D-1].pat;
    end
  end

  assign rdn         = rdn_q;
  assign col_addr    = col_q;
  assign row_addr    = row_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign {r, g, b}   = rgb_q;
endmodule
